// File: rtl/ftdi_pkg.sv
// rtl/ftdi_pkg.sv - shared types and pin-level constants for the FT232H sync FIFO emulator
package ftdi_pkg;

   typedef logic [7:0] byte_t;

   // FT232H strobes and flags are active low on the pins
   localparam logic FTDI_ASSERT   = 1'b0;
   localparam logic FTDI_DEASSERT = 1'b1;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock show-ahead FIFO with occupancy level
module sync_fifo_fwft #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      level,
   output logic             full,
   output logic             empty
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // a push into a full FIFO is accepted when a pop frees the slot in the same cycle
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (level == FULL_LVL);
   assign empty = (level == '0);

endmodule

// File: rtl/ftdi_dev_emu.sv
// rtl/ftdi_dev_emu.sv - device-side FT232H 245 sync FIFO emulator with host stream port
module ftdi_dev_emu
   import ftdi_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  byte_t       ftdi_data_in,
   output byte_t       ftdi_data_out,
   output logic        ftdi_data_oe,
   output logic        ftdi_rxf_n,
   output logic        ftdi_txe_n,
   input  logic        ftdi_rd_n,
   input  logic        ftdi_oe_n,
   input  logic        ftdi_wr_n,
   input  byte_t       host_tx_data,
   input  logic        host_tx_valid,
   output logic        host_tx_ready,
   output byte_t       host_rx_data,
   output logic        host_rx_valid,
   input  logic        host_rx_ready,
   output logic [AW:0] rx_level,
   output logic [AW:0] tx_level,
   output logic        err_overread,
   output logic        err_overwrite,
   output logic        err_contention
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   byte_t       rx_head;
   logic        rx_full;
   logic        rx_empty;
   logic        tx_full;
   logic        tx_empty;
   logic        rd_strobe;
   logic        rd_pop;
   logic        wr_strobe;
   logic        wr_push;
   logic        contention;
   logic        host_push;
   logic        host_pop;
   logic [AW:0] rx_level_next;
   logic [AW:0] tx_level_next;

   assign rd_strobe  = (ftdi_rd_n == FTDI_ASSERT) && (ftdi_oe_n == FTDI_ASSERT);
   assign rd_pop     = rd_strobe && (ftdi_rxf_n == FTDI_ASSERT);
   assign wr_strobe  = (ftdi_wr_n == FTDI_ASSERT);
   assign contention = wr_strobe && (ftdi_oe_n == FTDI_ASSERT);
   // writes are gated by the registered flag, so a bus-turnaround write is simply dropped
   assign wr_push    = wr_strobe && (ftdi_txe_n == FTDI_ASSERT) &&
                       (ftdi_oe_n == FTDI_DEASSERT) && !tx_full;

   assign host_tx_ready = ~reset & ~rx_full;
   assign host_push     = host_tx_valid & host_tx_ready;
   assign host_rx_valid = ~tx_empty;
   assign host_pop      = host_rx_valid & host_rx_ready;

   assign rx_level_next = rx_level + {{AW{1'b0}}, host_push} - {{AW{1'b0}}, rd_pop};
   assign tx_level_next = tx_level + {{AW{1'b0}}, wr_push} - {{AW{1'b0}}, host_pop};

   assign ftdi_data_oe  = ~ftdi_oe_n & ~reset;
   assign ftdi_data_out = rx_empty ? '0 : rx_head;

   sync_fifo_fwft #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (host_push),
      .pop   (rd_pop),
      .din   (host_tx_data),
      .dout  (rx_head),
      .level (rx_level),
      .full  (rx_full),
      .empty (rx_empty)
   );

   sync_fifo_fwft #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_push),
      .pop   (host_pop),
      .din   (ftdi_data_in),
      .dout  (host_rx_data),
      .level (tx_level),
      .full  (tx_full),
      .empty (tx_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ftdi_rxf_n     <= FTDI_DEASSERT;
         ftdi_txe_n     <= FTDI_DEASSERT;
         err_overread   <= 1'b0;
         err_overwrite  <= 1'b0;
         err_contention <= 1'b0;
      end else begin
         ftdi_rxf_n <= (rx_level_next == '0)      ? FTDI_DEASSERT : FTDI_ASSERT;
         ftdi_txe_n <= (tx_level_next == FULL_LVL) ? FTDI_DEASSERT : FTDI_ASSERT;
         if (rd_strobe && (ftdi_rxf_n == FTDI_DEASSERT)) err_overread <= 1'b1;
         if (wr_strobe && (ftdi_txe_n == FTDI_DEASSERT)) err_overwrite <= 1'b1;
         if (contention) err_contention <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ftdi_dev_emu.sv
// tb/tb_ftdi_dev_emu.sv - directed and randomized checks of ftdi_dev_emu against a queue model
module tb_ftdi_dev_emu;
   import ftdi_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic        clk = 1'b0;
   logic        reset;
   byte_t       ftdi_data_in;
   byte_t       ftdi_data_out;
   logic        ftdi_data_oe;
   logic        ftdi_rxf_n;
   logic        ftdi_txe_n;
   logic        ftdi_rd_n;
   logic        ftdi_oe_n;
   logic        ftdi_wr_n;
   byte_t       host_tx_data;
   logic        host_tx_valid;
   logic        host_tx_ready;
   byte_t       host_rx_data;
   logic        host_rx_valid;
   logic        host_rx_ready;
   logic [AW:0] rx_level;
   logic [AW:0] tx_level;
   logic        err_overread;
   logic        err_overwrite;
   logic        err_contention;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   byte_t rxq[$];
   byte_t txq[$];
   bit    m_rxf_n, m_txe_n, m_eo, m_ew, m_ec;

   always #5 clk = ~clk;

   ftdi_dev_emu #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .ftdi_data_in   (ftdi_data_in),
      .ftdi_data_out  (ftdi_data_out),
      .ftdi_data_oe   (ftdi_data_oe),
      .ftdi_rxf_n     (ftdi_rxf_n),
      .ftdi_txe_n     (ftdi_txe_n),
      .ftdi_rd_n      (ftdi_rd_n),
      .ftdi_oe_n      (ftdi_oe_n),
      .ftdi_wr_n      (ftdi_wr_n),
      .host_tx_data   (host_tx_data),
      .host_tx_valid  (host_tx_valid),
      .host_tx_ready  (host_tx_ready),
      .host_rx_data   (host_rx_data),
      .host_rx_valid  (host_rx_valid),
      .host_rx_ready  (host_rx_ready),
      .rx_level       (rx_level),
      .tx_level       (tx_level),
      .err_overread   (err_overread),
      .err_overwrite  (err_overwrite),
      .err_contention (err_contention)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_check();
      chk("rxf_n", ftdi_rxf_n, m_rxf_n);
      chk("txe_n", ftdi_txe_n, m_txe_n);
      chk("data_oe", ftdi_data_oe, !ftdi_oe_n && !reset);
      chk("data_out", ftdi_data_out, (rxq.size() != 0) ? rxq[0] : 8'h00);
      chk("host_tx_ready", host_tx_ready, !reset && (rxq.size() != DEPTH));
      chk("host_rx_valid", host_rx_valid, txq.size() != 0);
      if (txq.size() != 0) chk("host_rx_data", host_rx_data, txq[0]);
      chk("rx_level", rx_level, rxq.size());
      chk("tx_level", tx_level, txq.size());
      chk("err_overread", err_overread, m_eo);
      chk("err_overwrite", err_overwrite, m_ew);
      chk("err_contention", err_contention, m_ec);
   endtask

   // one clock: check outputs against the model mid-cycle, then advance the model at the edge
   task automatic step();
      bit rd, hp, rp, wp, hd;
      @(negedge clk);
      if (chk_en) model_check();
      @(posedge clk);
      if (reset) begin
         rxq.delete();
         txq.delete();
         m_rxf_n = 1'b1;
         m_txe_n = 1'b1;
         m_eo = 1'b0;
         m_ew = 1'b0;
         m_ec = 1'b0;
      end else begin
         rd = !ftdi_rd_n && !ftdi_oe_n;
         hp = host_tx_valid && (rxq.size() != DEPTH);
         rp = rd && !m_rxf_n;
         wp = !ftdi_wr_n && !m_txe_n && ftdi_oe_n;
         hd = (txq.size() != 0) && host_rx_ready;
         if (rd && m_rxf_n) m_eo = 1'b1;
         if (!ftdi_wr_n && m_txe_n) m_ew = 1'b1;
         if (!ftdi_oe_n && !ftdi_wr_n) m_ec = 1'b1;
         if (rp) void'(rxq.pop_front());
         if (hp) rxq.push_back(host_tx_data);
         if (hd) void'(txq.pop_front());
         if (wp) txq.push_back(ftdi_data_in);
         m_rxf_n = (rxq.size() == 0);
         m_txe_n = (txq.size() == DEPTH);
      end
      #1;
   endtask

   task automatic idle_inputs();
      ftdi_rd_n     = 1'b1;
      ftdi_oe_n     = 1'b1;
      ftdi_wr_n     = 1'b1;
      host_tx_valid = 1'b0;
      host_rx_ready = 1'b0;
      ftdi_data_in  = 8'h00;
      host_tx_data  = 8'h00;
   endtask

   initial begin
      byte_t burst[3];
      burst[0] = 8'h11;
      burst[1] = 8'h22;
      burst[2] = 8'h33;

      reset = 1'b1;
      idle_inputs();
      step();
      step();
      chk_en = 1'b1;
      reset  = 1'b0;
      for (int i = 0; i < 3; i++) step();
      #1;
      chk("idle_rxf_n", ftdi_rxf_n, 1'b1);
      chk("idle_txe_n", ftdi_txe_n, 1'b0);
      chk("idle_tx_ready", host_tx_ready, 1'b1);
      chk("idle_data_oe", ftdi_data_oe, 1'b0);
      chk("idle_errs", {err_overread, err_overwrite, err_contention}, 3'b000);

      for (int i = 0; i < 3; i++) begin
         host_tx_valid = 1'b1;
         host_tx_data  = burst[i];
         step();
      end
      host_tx_valid = 1'b0;
      ftdi_oe_n = 1'b0;
      step();
      ftdi_rd_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (i < 3) chk("burst_data", ftdi_data_out, burst[i]);
         if (i == 3) chk("burst_rxf_n", ftdi_rxf_n, 1'b1);
         if (i == 4) begin
            chk("burst_overread", err_overread, 1'b1);
            chk("burst_rx_level", rx_level, 0);
         end
         step();
      end
      idle_inputs();

      for (int i = 0; i <= DEPTH; i++) begin
         ftdi_wr_n    = 1'b0;
         ftdi_data_in = 8'hA0 + 8'(i);
         #1;
         if (i == DEPTH) chk("fill_txe_n", ftdi_txe_n, 1'b1);
         step();
      end
      ftdi_wr_n = 1'b1;
      step();
      chk("fill_overwrite", err_overwrite, 1'b1);
      chk("fill_head", host_rx_data, 8'hA0);
      chk("fill_level", tx_level, DEPTH);

      host_rx_ready = 1'b1;
      step();
      ftdi_wr_n    = 1'b0;
      ftdi_data_in = 8'h5A;
      #1;
      chk("simul_txe_n", ftdi_txe_n, 1'b0);
      step();
      host_rx_ready = 1'b0;
      ftdi_data_in  = 8'h5B;
      step();
      ftdi_wr_n = 1'b1;
      #1;
      chk("simul_level", tx_level, DEPTH);
      chk("simul_contention", err_contention, 1'b0);

      host_rx_ready = 1'b1;
      step();
      host_rx_ready = 1'b0;
      ftdi_oe_n    = 1'b0;
      ftdi_wr_n    = 1'b0;
      ftdi_data_in = 8'h77;
      step();
      idle_inputs();
      #1;
      chk("cont_flag", err_contention, 1'b1);
      chk("cont_level", tx_level, DEPTH - 1);
      host_rx_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) step();
      host_rx_ready = 1'b0;

      for (int i = 0; i < 10; i++) begin
         host_tx_valid = 1'b1;
         host_tx_data  = 8'($urandom);
         step();
      end
      host_tx_valid = 1'b0;
      ftdi_oe_n = 1'b0;
      step();
      ftdi_rd_n = 1'b0;
      step();
      step();
      chk("mid_level", rx_level, 8);
      reset = 1'b1;
      step();
      chk("rst_rx_level", rx_level, 0);
      chk("rst_rxf_n", ftdi_rxf_n, 1'b1);
      chk("rst_txe_n", ftdi_txe_n, 1'b1);
      reset = 1'b0;
      idle_inputs();
      step();
      step();
      chk("rel_txe_n", ftdi_txe_n, 1'b0);
      host_tx_valid = 1'b1;
      host_tx_data  = 8'hC1;
      step();
      host_tx_data  = 8'hC2;
      step();
      host_tx_valid = 1'b0;
      ftdi_oe_n = 1'b0;
      #1;
      chk("resume_data", ftdi_data_out, 8'hC1);
      step();

      for (int i = 0; i < 800; i++) begin
         reset         = ($urandom_range(0, 199) == 0);
         ftdi_oe_n     = ($urandom_range(0, 2) != 0);
         ftdi_rd_n     = ($urandom_range(0, 2) == 0);
         ftdi_wr_n     = ($urandom_range(0, 1) == 0);
         ftdi_data_in  = 8'($urandom);
         host_tx_valid = ($urandom_range(0, 1) == 0);
         host_tx_data  = 8'($urandom);
         host_rx_ready = ($urandom_range(0, 3) == 0);
         step();
      end
      reset = 1'b0;
      idle_inputs();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
